clk_ratio_ctrl: RTL and testbench

CLK_RATIO_CTRL -- requirements
Module: clk_ratio_ctrl

---
 rtl/clk_ratio_pkg.sv | 14 +
 rtl/clk_ratio_ctrl_ratio_counter.sv | 36 +++
 rtl/clk_ratio_ctrl.sv | 129 ++++++++++++
 tb/tb_clk_ratio_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_ratio_pkg.sv
// rtl/clk_ratio_pkg.sv - shared state type and ratio width helper for clk_ratio_ctrl
package clk_ratio_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int ratio_width(input int max_ratio);
        return $clog2(max_ratio + 1);
    endfunction

endpackage

// File: rtl/clk_ratio_ctrl_ratio_counter.sv
// rtl/clk_ratio_ctrl_ratio_counter.sv - period counter 0..ratio-1 with wrap flag and load-zero
module ratio_counter #(
    parameter int RW = 4
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          load_zero_i,
    input  logic [RW-1:0] ratio_i,
    output logic          wrap_o,
    output logic          zero_next_o
);

    logic [RW-1:0] cnt_q;
    logic [RW-1:0] cnt_d;

    // >= rather than == so a counter left above a shrunken ratio still recovers
    assign wrap_o = (cnt_q >= (ratio_i - RW'(1)));

    always_comb begin
        cnt_d = cnt_q + RW'(1);
        if (load_zero_i || wrap_o) begin
            cnt_d = '0;
        end
    end

    assign zero_next_o = (cnt_d == '0);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clk_ratio_ctrl.sv
// rtl/clk_ratio_ctrl.sv - gated periodic pulse generator with handshaked ratio reconfiguration
module clk_ratio_ctrl
    import clk_ratio_pkg::*;
#(
    parameter int  MAX_RATIO     = 8,
    parameter int  DEFAULT_RATIO = 1,
    localparam int RW            = ratio_width(MAX_RATIO)
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          enable,
    input  logic          cfg_valid,
    input  logic [RW-1:0] cfg_ratio,
    output logic          cfg_ready,
    output logic          cfg_done,
    output logic          cfg_err,
    output logic          pulse_out,
    output logic          busy,
    output logic [RW-1:0] active_ratio
);

    state_e        state_q;
    state_e        state_d;
    logic [RW-1:0] ratio_q;
    logic [RW-1:0] ratio_d;
    logic [RW-1:0] pend_q;
    logic [RW-1:0] pend_d;
    logic          pend_vld_q;
    logic          pend_vld_d;
    logic          done_q;
    logic          done_d;
    logic          err_q;
    logic          err_d;
    logic          pulse_q;
    logic          pulse_d;

    logic          wrap;
    logic          zero_next;
    logic          xfer;
    logic          cfg_ok;

    ratio_counter #(
        .RW (RW)
    ) u_counter (
        .clk_in      (clk_in),
        .rst         (rst),
        .load_zero_i (state_q == OFF),
        .ratio_i     (ratio_q),
        .wrap_o      (wrap),
        .zero_next_o (zero_next)
    );

    assign xfer   = cfg_valid && cfg_ready;
    assign cfg_ok = (cfg_ratio != '0) && (cfg_ratio <= RW'(MAX_RATIO));

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= OFF;
            ratio_q    <= RW'(DEFAULT_RATIO);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ratio_q    <= ratio_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            done_q     <= done_d;
            err_q      <= err_d;
            pulse_q    <= pulse_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ratio_d    = ratio_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        done_d     = 1'b0;
        err_d      = xfer && !cfg_ok;
        unique case (state_q)
            OFF: begin
                if (xfer && cfg_ok) begin
                    ratio_d = cfg_ratio;
                    done_d  = 1'b1;
                end
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (xfer && cfg_ok) begin
                    pend_d     = cfg_ratio;
                    pend_vld_d = 1'b1;
                    state_d    = DRAIN;
                end else if (!enable) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The current period always finishes before a new ratio or stop takes effect
                if (wrap) begin
                    if (pend_vld_q) begin
                        ratio_d    = pend_q;
                        done_d     = 1'b1;
                        pend_vld_d = 1'b0;
                    end
                    state_d = enable ? RUN : OFF;
                end
            end
            default: begin
                state_d = OFF;
            end
        endcase
        pulse_d = (state_d != OFF) && zero_next;
    end

    always_comb begin
        cfg_ready    = !rst && (state_q != DRAIN);
        busy         = (state_q != OFF);
        cfg_done     = done_q;
        cfg_err      = err_q;
        pulse_out    = pulse_q;
        active_ratio = ratio_q;
    end

endmodule

// File: tb/tb_clk_ratio_ctrl.sv
// tb/tb_clk_ratio_ctrl.sv - scoreboard bench for clk_ratio_ctrl against a period-level model
module tb_clk_ratio_ctrl;

    localparam int MAX_RATIO     = 8;
    localparam int DEFAULT_RATIO = 1;
    localparam int RW            = 4;

    logic          clk_in    = 1'b0;
    logic          rst       = 1'b1;
    logic          enable    = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [RW-1:0] cfg_ratio = '0;
    logic          cfg_ready;
    logic          cfg_done;
    logic          cfg_err;
    logic          pulse_out;
    logic          busy;
    logic [RW-1:0] active_ratio;

    clk_ratio_ctrl #(
        .MAX_RATIO     (MAX_RATIO),
        .DEFAULT_RATIO (DEFAULT_RATIO)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .enable       (enable),
        .cfg_valid    (cfg_valid),
        .cfg_ratio    (cfg_ratio),
        .cfg_ready    (cfg_ready),
        .cfg_done     (cfg_done),
        .cfg_err      (cfg_err),
        .pulse_out    (pulse_out),
        .busy         (busy),
        .active_ratio (active_ratio)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic          pulse;
        logic          busy;
        logic          ready;
        logic          done;
        logic          err;
        logic [RW-1:0] ratio;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: running/draining flags, position within the period, period length, pending ratio (0 = none)
    bit m_running;
    bit m_draining;
    int m_pos;
    int m_period;
    int m_pending;

    function automatic void model_reset();
        m_running  = 1'b0;
        m_draining = 1'b0;
        m_pos      = 0;
        m_period   = DEFAULT_RATIO;
        m_pending  = 0;
    endfunction

    function automatic void model_step(input bit en, input bit v, input int r);
        bit   xfer;
        bit   ok;
        bit   done;
        bit   err;
        bit   at_end;
        obs_t o;
        xfer = v && !(m_running && m_draining);
        ok   = (r >= 1) && (r <= MAX_RATIO);
        err  = xfer && !ok;
        done = 1'b0;
        if (!m_running) begin
            if (xfer && ok) begin
                m_period = r;
                done     = 1'b1;
            end
            if (en) begin
                m_running = 1'b1;
                m_pos     = 0;
            end
        end else begin
            at_end = (m_pos == m_period - 1);
            m_pos  = at_end ? 0 : m_pos + 1;
            if (!m_draining) begin
                if (xfer && ok) begin
                    m_pending  = r;
                    m_draining = 1'b1;
                end else if (!en) begin
                    m_draining = 1'b1;
                end
            end else if (at_end) begin
                if (m_pending > 0) begin
                    m_period  = m_pending;
                    done      = 1'b1;
                    m_pending = 0;
                end
                m_draining = 1'b0;
                m_running  = en;
            end
        end
        o.pulse = m_running && (m_pos == 0);
        o.busy  = m_running;
        o.ready = !(m_running && m_draining);
        o.done  = done;
        o.err   = err;
        o.ratio = RW'(m_period);
        exp_q.push_back(o);
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pulse"}, int'(pulse_out), 0);
        check({tag, "_busy"},  int'(busy), 0);
        check({tag, "_ready"}, int'(cfg_ready), 0);
        check({tag, "_done"},  int'(cfg_done), 0);
        check({tag, "_err"},   int'(cfg_err), 0);
        check({tag, "_ratio"}, int'(active_ratio), DEFAULT_RATIO);
    endtask

    task automatic step(input bit en, input bit v, input int r);
        @(negedge clk_in);
        enable    = en;
        cfg_valid = v;
        cfg_ratio = RW'(r);
        model_step(en, v, r);
    endtask

    task automatic release_reset();
        @(negedge clk_in);
        rst       = 1'b0;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        model_reset();
        model_step(1'b0, 1'b0, 0);
    endtask

    task automatic go_off();
        for (int i = 0; i < 24 && m_running; i++) step(1'b0, 1'b0, 0);
        check("go_off_timeout", int'(m_running), 0);
    endtask

    task automatic run_until_pos(input int p);
        for (int i = 0; i < 24 && !(m_running && m_pos == p); i++) step(1'b1, 1'b0, 0);
        check("run_until_pos_timeout", int'(m_running && m_pos == p), 1);
    endtask

    initial begin : monitor
        obs_t e;
        obs_t g;
        forever begin
            @(posedge clk_in);
            #1;
            if (exp_q.size() > 0) begin
                e       = exp_q.pop_front();
                g.pulse = pulse_out;
                g.busy  = busy;
                g.ready = cfg_ready;
                g.done  = cfg_done;
                g.err   = cfg_err;
                g.ratio = active_ratio;
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL cycle t=%0t got pulse=%b busy=%b ready=%b done=%b err=%b ratio=%0d expected pulse=%b busy=%b ready=%b done=%b err=%b ratio=%0d",
                             $time, g.pulse, g.busy, g.ready, g.done, g.err, g.ratio,
                             e.pulse, e.busy, e.ready, e.done, e.err, e.ratio);
                end
            end
        end
    end

    initial begin : stimulus
        bit en_r;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        check_reset_outputs("reset");
        release_reset();

        // ratio 1: pulse every cycle once running
        repeat (6) step(1'b1, 1'b0, 0);

        // ratio 4, disable at cnt 0: three more cycles then OFF
        go_off();
        step(1'b0, 1'b1, 4);
        step(1'b1, 1'b0, 0);
        run_until_pos(0);
        step(1'b0, 1'b0, 0);
        repeat (5) step(1'b0, 1'b0, 0);

        // ratio 4 running, offer 3 at cnt 1
        step(1'b1, 1'b0, 0);
        run_until_pos(1);
        step(1'b1, 1'b1, 3);
        repeat (12) step(1'b1, 1'b0, 0);

        // out-of-range ratios in OFF
        go_off();
        step(1'b0, 1'b1, 0);
        step(1'b0, 1'b1, 9);
        step(1'b0, 1'b0, 0);

        // disable and new ratio together at ratio 5
        step(1'b0, 1'b1, 5);
        step(1'b1, 1'b0, 0);
        run_until_pos(2);
        step(1'b0, 1'b1, 2);
        repeat (8) step(1'b0, 1'b0, 0);

        // reset asserted mid-clock while draining with a pending ratio
        step(1'b0, 1'b1, 5);
        step(1'b1, 1'b0, 0);
        run_until_pos(1);
        step(1'b1, 1'b1, 7);
        @(posedge clk_in);
        #2;
        check("drain_ready_low", int'(cfg_ready), 0);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk_in);
        #1;
        check_reset_outputs("mid_reset_held");
        release_reset();
        repeat (3) step(1'b0, 1'b0, 0);

        en_r = 1'b1;
        for (int i = 0; i < 600; i++) begin
            int r;
            bit v;
            if ($urandom_range(0, 19) == 0) en_r = !en_r;
            v = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, MAX_RATIO));
            step(en_r, v, r);
        end
        step(1'b0, 1'b0, 0);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk_in);
        #2;
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
